// File: rtl/retospect_cfg_pkg.sv
// Shared state encoding and chain geometry for the bitstream loader.
package retospect_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SHIFT,
    NNRST
  } state_t;

  localparam int CELL_BITS     = 19;
  localparam int CLOCKBOX_BITS = 48;

  // Total chain length for an x-by-y cell array behind the clockbox.
  function automatic int chain_len(input int x, input int y);
    return CLOCKBOX_BITS + x * y * CELL_BITS;
  endfunction

endpackage

// File: rtl/retospect_rb_packer.sv
// Collects bits falling out of the chain tail into readback bytes and
// holds each completed byte until the consumer takes it.
module retospect_rb_packer (
  input  logic       clk,
  input  logic       reset,
  input  logic       shift_req,
  input  logic       sample,
  input  logic       last_bit,
  input  logic       rb_ready,
  output logic [7:0] rb_data,
  output logic       rb_valid,
  output logic       full
);

  logic [7:0] rb_sr;
  logic [2:0] rb_cnt;
  logic       due;
  logic       shift_en;
  logic [7:0] rb_next;

  // A transfer is due on the 8th bit or on the final chain bit; it can only
  // proceed once the holding register is empty or being emptied this cycle.
  always_comb begin
    due      = shift_req && ((rb_cnt == 3'd7) || last_bit);
    full     = rb_valid && !rb_ready && due;
    shift_en = shift_req && !full;
    rb_next  = {sample, rb_sr[7:1]};
  end

  // Shift register, holding register and valid flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rb_sr    <= '0;
      rb_cnt   <= '0;
      rb_data  <= '0;
      rb_valid <= 1'b0;
    end else begin
      if (rb_valid && rb_ready) rb_valid <= 1'b0;
      // NOTE: a later non-blocking assignment to the same flop wins, so a new
      // transfer below overrides the acceptance clear above in the same cycle.
      if (shift_en) begin
        if (due) begin
          // Right-align a short final byte; the unused upper bits fall out as 0.
          rb_data  <= rb_next >> (3'd7 - rb_cnt);
          rb_valid <= 1'b1;
          rb_sr    <= '0;
          rb_cnt   <= '0;
        end else begin
          rb_sr  <= rb_next;
          rb_cnt <= rb_cnt + 3'd1;
        end
      end
    end
  end

endmodule

// File: rtl/retospect_bitstream_loader.sv
// Serial configuration master: streams bytes LSB first into the fabric
// chain, returns the displaced bits as readback, then pulses reset_nn.
module retospect_bitstream_loader
  import retospect_cfg_pkg::*;
#(
  parameter int CHAIN_LEN = chain_len(7, 10),
  parameter int CNT_W     = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             cfg_en,
  output logic             cfg_bs,
  input  logic             cfg_bs_ret,
  output logic             cfg_nn_reset,
  output logic [7:0]       rb_data,
  output logic             rb_valid,
  input  logic             rb_ready,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] bit_count
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN);

  state_t           state, state_nx;
  logic [7:0]       tx_sr;
  logic [3:0]       nbits;
  logic [3:0]       nbits_load;
  logic [CNT_W-1:0] remaining;
  logic             shift_req;
  logic             load_start;
  logic             last_bit;
  logic             rb_full;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state and control decode.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // through the case statement leaves a latch behind.
    state_nx     = state;
    s_ready      = 1'b0;
    shift_req    = 1'b0;
    cfg_nn_reset = 1'b0;
    load_start   = 1'b0;
    case (state)
      IDLE: begin
        // A pending readback byte must drain before the next load begins.
        if (start && !rb_valid) begin
          state_nx   = FETCH;
          load_start = 1'b1;
        end
      end
      FETCH: begin
        s_ready = 1'b1;
        if (s_valid) state_nx = SHIFT;
      end
      SHIFT: begin
        if (nbits == 4'd0) state_nx = (bit_count == LAST) ? NNRST : FETCH;
        else               shift_req = 1'b1;
      end
      NNRST: begin
        cfg_nn_reset = 1'b1;
        state_nx     = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Shift enable, chain data and byte sizing for the final partial byte.
  always_comb begin
    cfg_en     = shift_req && !rb_full;
    cfg_bs     = cfg_en & tx_sr[0];
    busy       = (state != IDLE);
    last_bit   = (bit_count == LAST - 1'b1);
    remaining  = LAST - bit_count;
    nbits_load = (int'(remaining) >= 8) ? 4'd8 : 4'(remaining);
  end

  // Transmit shifter, per-byte bit budget, load counter and done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_sr     <= '0;
      nbits     <= '0;
      bit_count <= '0;
      done      <= 1'b0;
    end else begin
      done <= (state == NNRST);
      if (load_start) bit_count <= '0;
      if (state == FETCH && s_valid) begin
        tx_sr <= s_data;
        nbits <= nbits_load;
      end
      if (cfg_en) begin
        tx_sr     <= tx_sr >> 1;
        nbits     <= nbits - 4'd1;
        bit_count <= bit_count + 1'b1;
      end
    end
  end

  retospect_rb_packer u_rb_packer (
    .clk      (clk),
    .reset    (reset),
    .shift_req(shift_req),
    .sample   (cfg_bs_ret),
    .last_bit (last_bit),
    .rb_ready (rb_ready),
    .rb_data  (rb_data),
    .rb_valid (rb_valid),
    .full     (rb_full)
  );

endmodule

// File: tb/tb_retospect_bitstream_loader.sv
// Bench for the bitstream loader: a 12-bit chain instance for directed
// table vectors and corner sequences, and a full-size instance driven with
// random bytes against a bit-stream reference model.
module tb_retospect_bitstream_loader;

  localparam int BIG_LEN = 1378;
  localparam int BIG_BYTES = (BIG_LEN + 7) / 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // ---------------- small instance (12-bit chain) ----------------
  logic       start = 1'b0, s_valid = 1'b0, rb_ready = 1'b1;
  logic [7:0] s_data = '0;
  logic       s_ready, cfg_en, cfg_bs, cfg_bs_ret, cfg_nn_reset, rb_valid, busy, done;
  logic [7:0] rb_data;
  logic [3:0] bit_count;

  retospect_bitstream_loader #(.CHAIN_LEN(12), .CNT_W(4)) dut_s (
    .clk(clk), .reset(reset), .start(start), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .cfg_en(cfg_en), .cfg_bs(cfg_bs), .cfg_bs_ret(cfg_bs_ret),
    .cfg_nn_reset(cfg_nn_reset), .rb_data(rb_data), .rb_valid(rb_valid),
    .rb_ready(rb_ready), .busy(busy), .done(done), .bit_count(bit_count)
  );

  // ---------------- full-size instance ----------------
  logic        b_start = 1'b0, b_s_valid = 1'b0, b_rb_ready = 1'b1;
  logic [7:0]  b_s_data = '0;
  logic        b_s_ready, b_cfg_en, b_cfg_bs, b_cfg_bs_ret, b_cfg_nn_reset, b_rb_valid, b_busy, b_done;
  logic [7:0]  b_rb_data;
  logic [10:0] b_bit_count;

  retospect_bitstream_loader dut_b (
    .clk(clk), .reset(reset), .start(b_start), .s_data(b_s_data), .s_valid(b_s_valid),
    .s_ready(b_s_ready), .cfg_en(b_cfg_en), .cfg_bs(b_cfg_bs), .cfg_bs_ret(b_cfg_bs_ret),
    .cfg_nn_reset(b_cfg_nn_reset), .rb_data(b_rb_data), .rb_valid(b_rb_valid),
    .rb_ready(b_rb_ready), .busy(b_busy), .done(b_done), .bit_count(b_bit_count)
  );

  // ---------------- chain models: shift in at MSB, tail is bit 0 ----------------
  logic [11:0]        chain = '0, chain_init = '0;
  logic               chain_load = 1'b0;
  logic [BIG_LEN-1:0] b_chain = '0, b_chain_init = '0;
  logic               b_chain_load = 1'b0;

  always @(posedge clk) begin
    if (chain_load)  chain <= chain_init;
    else if (cfg_en) chain <= {cfg_bs, chain[11:1]};
    if (b_chain_load)  b_chain <= b_chain_init;
    else if (b_cfg_en) b_chain <= {b_cfg_bs, b_chain[BIG_LEN-1:1]};
  end
  assign cfg_bs_ret   = chain[0];
  assign b_cfg_bs_ret = b_chain[0];

  // ---------------- monitors (sampled on the falling edge) ----------------
  int   cyc_cnt = 0;
  logic bs_log [512];
  logic [7:0] rb_log [64];
  int   bs_n = 0, rb_n = 0, nn_n = 0, dn_n = 0;
  logic b_bs_log [2048];
  logic [7:0] b_rb_log [256];
  int   b_bs_n = 0, b_rb_n = 0, b_nn_n = 0, b_dn_n = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(negedge clk) begin
    if (cfg_en) begin
      if (bs_n < 512) bs_log[bs_n] <= cfg_bs;
      bs_n <= bs_n + 1;
    end
    if (rb_valid && rb_ready) begin
      if (rb_n < 64) rb_log[rb_n] <= rb_data;
      rb_n <= rb_n + 1;
    end
    if (cfg_nn_reset) nn_n <= nn_n + 1;
    if (done)         dn_n <= dn_n + 1;
    if (b_cfg_en) begin
      if (b_bs_n < 2048) b_bs_log[b_bs_n] <= b_cfg_bs;
      b_bs_n <= b_bs_n + 1;
    end
    if (b_rb_valid && b_rb_ready) begin
      if (b_rb_n < 256) b_rb_log[b_rb_n] <= b_rb_data;
      b_rb_n <= b_rb_n + 1;
    end
    if (b_cfg_nn_reset) b_nn_n <= b_nn_n + 1;
    if (b_done)         b_dn_n <= b_dn_n + 1;
  end

  // ---------------- checking ----------------
  int n_vec = 0, n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_chain(input logic [11:0] v);
    chain_init = v;
    chain_load = 1'b1;
    tick();
    chain_load = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, output bit ok);
    int cyc = 0;
    s_data  = d;
    s_valid = 1'b1;
    while (!s_ready && cyc < 100) begin tick(); cyc++; end
    ok = s_ready;
    tick();
    s_valid = 1'b0;
  endtask

  task automatic big_send(input logic [7:0] d, output bit ok);
    int cyc = 0;
    b_s_data  = d;
    b_s_valid = 1'b1;
    while (!b_s_ready && cyc < 100) begin tick(); cyc++; end
    ok = b_s_ready;
    tick();
    b_s_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int cyc = 0;
    while (busy && cyc < 200) begin tick(); cyc++; end
    check({tag, "_idle"}, busy, 1'b0);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [7:0]  b0, b1;
    logic [11:0] pre;
    int          gap;
    int          stall;
    logic [7:0]  rb0, rb1;
    logic [11:0] chain_end;
  } vec_t;

  vec_t tbl [6];

  // One 12-bit load: table drives the bytes, gap, stall and expected results.
  task automatic run_small(input vec_t v, input string tag);
    int bs0, rb0, nn0, dn0, t0, cyc, en_gap;
    bit ok;
    logic [11:0] got, snap, exp_bs;
    load_chain(v.pre);
    bs0 = bs_n; rb0 = rb_n; nn0 = nn_n; dn0 = dn_n;
    rb_ready = (v.stall == 0);
    s_data = v.b0; s_valid = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    t0 = cyc_cnt;
    check({tag, "_fetch_ready"}, s_ready, 1'b1);
    tick();
    s_valid = 1'b0;
    check({tag, "_first_en"}, cfg_en, 1'b1);
    if (v.gap > 0) begin
      cyc = 0;
      while (!s_ready && cyc < 100) begin tick(); cyc++; end
      snap = chain;
      en_gap = 0;
      repeat (v.gap) begin
        if (cfg_en) en_gap++;
        tick();
      end
      check({tag, "_gap_en"}, en_gap, 0);
      check({tag, "_gap_chain"}, chain, snap);
    end
    send_byte(v.b1, ok);
    check({tag, "_byte1_taken"}, ok, 1'b1);
    if (v.stall > 0) begin
      repeat (v.stall) @(posedge clk);
      #1;
      check({tag, "_stall"}, {cfg_en, rb_valid, bit_count, rb_data}, {1'b0, 1'b1, 4'd11, v.rb0});
      rb_ready = 1'b1;
    end
    wait_idle(tag);
    if (v.gap == 0 && v.stall == 0) check({tag, "_cycles"}, cyc_cnt - t0, 17);
    repeat (3) tick();
    exp_bs = {v.b1[3:0], v.b0};
    for (int i = 0; i < 12; i++) got[i] = bs_log[(bs0 + i) % 512];
    check({tag, "_en_count"}, bs_n - bs0, 12);
    check({tag, "_bs_seq"}, got, exp_bs);
    check({tag, "_rb_count"}, rb_n - rb0, 2);
    check({tag, "_rb0"}, rb_log[rb0 % 64], v.rb0);
    check({tag, "_rb1"}, rb_log[(rb0 + 1) % 64], v.rb1);
    check({tag, "_chain"}, chain, v.chain_end);
    check({tag, "_nnrst"}, nn_n - nn0, 1);
    check({tag, "_done"}, dn_n - dn0, 1);
    check({tag, "_bit_count"}, bit_count, 4'd12);
  endtask

  // ---------------- full-size random load ----------------
  bit big_fin = 1'b0;
  int big_nok = 0;

  task automatic run_big();
    logic [BIG_LEN-1:0] pre;
    logic [7:0] bytes [BIG_BYTES];
    logic [7:0] exp;
    logic sent;
    int bs0, rb0, nn0, dn0, cyc, bs_bad, ch_bad;
    for (int i = 0; i < BIG_LEN; i++) pre[i] = 1'($urandom_range(0, 1));
    for (int k = 0; k < BIG_BYTES; k++) bytes[k] = 8'($urandom);
    b_chain_init = pre;
    b_chain_load = 1'b1;
    tick();
    b_chain_load = 1'b0;
    bs0 = b_bs_n; rb0 = b_rb_n; nn0 = b_nn_n; dn0 = b_dn_n;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    fork
      begin
        bit ok;
        for (int k = 0; k < BIG_BYTES; k++) begin
          repeat ($urandom_range(0, 2)) tick();
          big_send(bytes[k], ok);
          if (!ok) big_nok++;
        end
        cyc = 0;
        while (b_busy && cyc < 200) begin tick(); cyc++; end
        big_fin = 1'b1;
      end
      begin
        while (!big_fin) begin
          tick();
          b_rb_ready = ($urandom_range(0, 3) != 0);
        end
        b_rb_ready = 1'b1;
      end
    join
    repeat (4) tick();
    check("big_bytes_taken", big_nok, 0);
    check("big_idle", b_busy, 1'b0);
    check("big_rb_count", b_rb_n - rb0, BIG_BYTES);
    // Readback must reproduce the preloaded chain, tail bit first, LSB first.
    for (int k = 0; k < BIG_BYTES; k++) begin
      exp = '0;
      for (int j = 0; j < 8; j++)
        if (8 * k + j < BIG_LEN) exp[j] = pre[8 * k + j];
      check($sformatf("big_rb%0d", k), b_rb_log[(rb0 + k) % 256], exp);
    end
    exp = b_rb_log[(rb0 + BIG_BYTES - 1) % 256];
    check("big_last_upper", exp[7:2], 6'd0);
    // Shifted stream and final chain must equal the byte stream, LSB first.
    bs_bad = 0;
    ch_bad = 0;
    for (int i = 0; i < BIG_LEN; i++) begin
      sent = bytes[i / 8][i % 8];
      if (b_bs_log[(bs0 + i) % 2048] !== sent) bs_bad++;
      if (b_chain[i] !== sent) ch_bad++;
    end
    check("big_en_count", b_bs_n - bs0, BIG_LEN);
    check("big_bs_bits_wrong", bs_bad, 0);
    check("big_chain_bits_wrong", ch_bad, 0);
    check("big_bit_count", b_bit_count, 11'd1378);
    check("big_nnrst", b_nn_n - nn0, 1);
    check("big_done", b_dn_n - dn0, 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cyc, rb0, dn0, nn0, bs0;
    bit ok;
    logic [7:0]  a5;
    logic [11:0] exp_chain;

    tbl[0] = '{8'hA5, 8'h03, 12'hFFF, 0, 0,  8'hFF, 8'h0F, 12'h3A5};
    tbl[1] = '{8'hA5, 8'h03, 12'hFFF, 5, 0,  8'hFF, 8'h0F, 12'h3A5};
    tbl[2] = '{8'hA5, 8'h03, 12'hFFF, 0, 20, 8'hFF, 8'h0F, 12'h3A5};
    tbl[3] = '{8'h3C, 8'hFE, 12'h5A3, 0, 0,  8'hA3, 8'h05, 12'hE3C};
    tbl[4] = '{8'h00, 8'hFF, 12'h000, 2, 0,  8'h00, 8'h00, 12'hF00};
    tbl[5] = '{8'h5E, 8'hF9, 12'h0F0, 3, 20, 8'hF0, 8'h00, 12'h95E};

    // Reset state of both instances.
    #3;
    check("reset_small", {s_ready, cfg_en, cfg_bs, cfg_nn_reset, rb_data, rb_valid, busy, done, bit_count}, '0);
    check("reset_big", {b_s_ready, b_cfg_en, b_cfg_bs, b_cfg_nn_reset, b_rb_data, b_rb_valid, b_busy, b_done, b_bit_count}, '0);
    tick();
    reset = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) run_small(tbl[i], $sformatf("v%0d", i));

    // Reset in the middle of the first byte: everything drops at once.
    load_chain(12'hFFF);
    rb0 = rb_n; dn0 = dn_n;
    s_data = 8'hA5; s_valid = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    s_valid = 1'b0;
    cyc = 0;
    while (bit_count != 4'd5 && cyc < 50) begin tick(); cyc++; end
    check("rst_reached_bit5", {cfg_en, bit_count}, {1'b1, 4'd5});
    #2 reset = 1'b1;
    #1;
    check("rst_async_outputs", {s_ready, cfg_en, cfg_bs, cfg_nn_reset, rb_data, rb_valid, busy, done, bit_count}, '0);
    tick();
    reset = 1'b0;
    repeat (4) tick();
    a5 = 8'hA5;
    exp_chain = {a5[4:0], 7'h7F};
    check("rst_chain_kept", chain, exp_chain);
    check("rst_no_done_no_rb", {busy, 8'(dn_n - dn0), 8'(rb_n - rb0)}, '0);
    run_small(tbl[0], "after_rst");

    // start while busy and while a readback byte is still pending.
    load_chain(12'hFFF);
    rb0 = rb_n; dn0 = dn_n; nn0 = nn_n; bs0 = bs_n;
    rb_ready = 1'b0;
    s_data = 8'hA5; s_valid = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    s_valid = 1'b0;
    cyc = 0;
    while (bit_count != 4'd3 && cyc < 50) begin tick(); cyc++; end
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy_ignored", {busy, bit_count}, {1'b1, 4'd4});
    send_byte(8'h03, ok);
    check("poke_byte1_taken", ok, 1'b1);
    repeat (20) tick();
    rb_ready = 1'b1;
    tick();
    rb_ready = 1'b0;
    wait_idle("poke");
    check("poke_rb_pending", {rb_valid, rb_data}, {1'b1, 8'h0F});
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    check("start_pending_ignored", {busy, bit_count}, {1'b0, 4'd12});
    rb_ready = 1'b1;
    repeat (3) tick();
    check("poke_rb_count", rb_n - rb0, 2);
    check("poke_rb_bytes", {rb_log[rb0 % 64], rb_log[(rb0 + 1) % 64]}, 16'hFF0F);
    check("poke_en_count", bs_n - bs0, 12);
    check("poke_one_done", {8'(dn_n - dn0), 8'(nn_n - nn0)}, 16'h0101);

    run_big();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
